v_alu_issue: RTL and testbench

- Issue/result stage wrapped around the vector SIMD ALU. It accepts vector operations with a valid/ready handshake and buffers them in a small FIFO.
- Drives the head entry's S/T/C/FS combinationally into the vector ALU, then captures the ALU result Y into a registered writeback slot tagged with its destination vector register.
- Decouples vector decode from vector register-file writeback.

---
 rtl/v_alu_issue.sv | 149 ++++++++++++++
 tb/tb_v_alu_issue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_alu_issue.sv
// v_alu_issue: issue/result stage around the vector SIMD ALU.
// Ops enter through a valid/ready handshake into a DEPTH-entry FIFO. The head
// entry drives the ALU combinationally. On pop, the ALU result is captured into
// a registered writeback slot, tagged with the op's destination register.
// Optional build macro V_ALU_PERF_CNT_EN adds the perf_ops and perf_stall
// counters as extra output ports.
module v_alu_issue #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_fs,
  input  logic [63:0]   in_s,
  input  logic [63:0]   in_t,
  input  logic [63:0]   in_c,
  input  logic [2:0]    in_dst,
  output logic [4:0]    alu_fs,
  output logic [63:0]   alu_s,
  output logic [63:0]   alu_t,
  output logic [63:0]   alu_c,
  input  logic [63:0]   alu_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_y,
  output logic [2:0]    out_dst,
  output logic          out_illegal,
  output logic [AW:0]   count
`ifdef V_ALU_PERF_CNT_EN
  ,
  output logic [31:0]   perf_ops,
  output logic [31:0]   perf_stall
`endif
);

  // Entry layout, MSB to LSB: fs[4:0], s[63:0], t[63:0], c[63:0], dst[2:0].
  localparam int EW = 5 + 64 * 3 + 3;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          head_legal;
  logic [EW-1:0] head_ent;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign count    = cnt;
  assign head_ent = mem[head];

  // in_ready depends only on registered occupancy, so a full FIFO refuses a push
  // even in a cycle where a pop frees an entry.
  assign push = in_valid && !full && !flush;
  assign pop  = !empty && (!out_valid || out_ready) && !flush;

  // Drive the ALU from the head entry. When the FIFO is empty, drive a harmless
  // PASS_S with zero operands.
  always_comb begin
    alu_fs = 5'h0B;
    alu_s  = '0;
    alu_t  = '0;
    alu_c  = '0;
    if (!empty) begin
      alu_fs = head_ent[199:195];
      alu_s  = head_ent[194:131];
      alu_t  = head_ent[130:67];
      alu_c  = head_ent[66:3];
    end
  end

  // Decide whether the head op's function code is one the ALU implements.
  // Code 08 (VPACK) is deliberately excluded.
  always_comb begin
    head_legal = 1'b0;
    case (alu_fs)
      5'h00, 5'h01, 5'h02, 5'h03, 5'h06, 5'h07, 5'h09, 5'h0A, 5'h0B:
        head_legal = 1'b1;
      default: head_legal = 1'b0;
    endcase
  end

  // FIFO storage is written at the tail on push. The data needs no reset
  // because occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {in_fs, in_s, in_t, in_c, in_dst};
    end
  end

  // FIFO pointers and occupancy. Flush takes priority over push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Writeback slot: capture the ALU result on pop, or empty the slot once its
  // result is accepted and nothing follows. Data and tag hold when the slot empties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_y       <= '0;
      out_dst     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid   <= 1'b1;
      out_dst     <= head_ent[2:0];
      out_y       <= head_legal ? alu_y : '0;
      out_illegal <= !head_legal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef V_ALU_PERF_CNT_EN
  // Accepted-result and stall-cycle counters. They wrap freely, and flush does
  // not clear them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready)  perf_ops   <= perf_ops + 32'd1;
      if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_v_alu_issue.sv
// Testbench for v_alu_issue. The bench acts as the vector ALU and checks the
// DUT against a queue-based reference model.
module tb_v_alu_issue;
  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_fs = '0;
  logic [63:0]   in_s = '0, in_t = '0, in_c = '0;
  logic [2:0]    in_dst = '0;
  logic [4:0]    alu_fs;
  logic [63:0]   alu_s, alu_t, alu_c, alu_y;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_y;
  logic [2:0]    out_dst;
  logic          out_illegal;
  logic [AW:0]   count;
`ifdef V_ALU_PERF_CNT_EN
  logic [31:0]   perf_ops, perf_stall;
`endif

  always #5 clk = ~clk;

  // Stand-in ALU: op 00 is a saturating unsigned byte add, 0B passes S, and
  // every other code gives a mix of S, T, C and the code.
  function automatic logic [63:0] tb_alu(input logic [4:0] fs, input logic [63:0] s,
                                         input logic [63:0] t, input logic [63:0] c);
    logic [63:0] r;
    logic [8:0]  sum;
    r = '0;
    case (fs)
      5'h00: for (int i = 0; i < 8; i++) begin
        sum = {1'b0, s[i*8 +: 8]} + {1'b0, t[i*8 +: 8]};
        r[i*8 +: 8] = sum[8] ? 8'hFF : sum[7:0];
      end
      5'h0B: r = s;
      default: r = (s ^ {t[31:0], t[63:32]}) + c + 64'(fs);
    endcase
    return r;
  endfunction

  function automatic bit legal(input logic [4:0] fs);
    return fs inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h06, 5'h07, 5'h09, 5'h0A, 5'h0B};
  endfunction

  assign alu_y = tb_alu(alu_fs, alu_s, alu_t, alu_c);

  v_alu_issue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fs(in_fs), .in_s(in_s), .in_t(in_t), .in_c(in_c), .in_dst(in_dst),
    .alu_fs(alu_fs), .alu_s(alu_s), .alu_t(alu_t), .alu_c(alu_c), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_dst(out_dst), .out_illegal(out_illegal), .count(count)
`ifdef V_ALU_PERF_CNT_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  typedef struct {
    logic [4:0]  fs;
    logic [63:0] s, t, c;
    logic [2:0]  dst;
  } op_t;

  op_t         q[$];
  bit          m_sv;
  logic [63:0] m_y;
  logic [2:0]  m_dst;
  bit          m_ill;
  logic [31:0] m_ops, m_stall;
  int          total = 0;
  int          bad = 0;
  int          accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(m_sv));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("count", 64'(count), 64'(q.size()));
    chk("out_y", out_y, m_y);
    chk("out_dst", 64'(out_dst), 64'(m_dst));
    chk("out_illegal", 64'(out_illegal), 64'(m_ill));
    chk("alu_fs", 64'(alu_fs), (q.size() > 0) ? 64'(q[0].fs) : 64'h0B);
    chk("alu_s", alu_s, (q.size() > 0) ? q[0].s : 64'h0);
`ifdef V_ALU_PERF_CNT_EN
    chk("perf_ops", 64'(perf_ops), 64'(m_ops));
    chk("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
  endtask

  // Advance the reference model by one edge using the inputs that are stable
  // now, clock the DUT, then compare just after the edge.
  task automatic cyc();
    op_t o;
    bit  pop, push;
    if (m_sv && out_ready)  m_ops++;
    if (m_sv && !out_ready) m_stall++;
    if (flush) begin
      q.delete();
      m_sv = 0;
    end else begin
      pop  = (q.size() > 0) && (!m_sv || out_ready);
      push = in_valid && (q.size() < DEPTH);
      if (pop) begin
        o = q.pop_front();
        m_sv = 1;
        m_dst = o.dst;
        m_ill = !legal(o.fs);
        m_y = m_ill ? 64'h0 : tb_alu(o.fs, o.s, o.t, o.c);
      end else if (m_sv && out_ready) begin
        m_sv = 0;
      end
      if (push) begin
        o.fs = in_fs; o.s = in_s; o.t = in_t; o.c = in_c; o.dst = in_dst;
        q.push_back(o);
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [4:0] fs, input logic [63:0] s,
                       input logic [63:0] t, input logic [63:0] c, input logic [2:0] dst);
    in_valid = v; in_fs = fs; in_s = s; in_t = t; in_c = c; in_dst = dst;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 5'h0, 64'h0, 64'h0, 64'h0, 3'h0);
    q.delete();
    m_sv = 0; m_y = '0; m_dst = '0; m_ill = 0; m_ops = '0; m_stall = '0;
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    logic [4:0] rfs;

    // Reset state and the first-op latency.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 5'h00, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_0020, 64'h0, 3'd3);
    cyc();
    drive(1'b0, 5'h0, 64'h0, 64'h0, 64'h0, 3'h0);
    chk("lat_not_yet", 64'(out_valid), 64'h0);
    cyc();
    chk("lat_valid", 64'(out_valid), 64'h1);
    chk("addus_sat", out_y, 64'h0000_0000_0000_00FF);
    chk("addus_dst", 64'(out_dst), 64'd3);
    chk("addus_legal", 64'(out_illegal), 64'h0);
    cyc();

    // Backpressure fills the FIFO; a full FIFO refuses a push even while popping.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'h01, 64'(k + 16), 64'(k * 3), 64'h5, 3'(k));
      cyc();
    end
    chk("bp_count", 64'(count), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'h0);
    drive(1'b1, 5'h02, 64'h99, 64'h1, 64'h2, 3'd7);
    out_ready = 1'b1;
    cyc();
    chk("full_pop_dst", 64'(out_dst), 64'd1);
    chk("full_no_push", 64'(count), 64'd1);
    drive(1'b0, 5'h0, 64'h0, 64'h0, 64'h0, 3'h0);
    for (int k = 0; k < 3; k++) cyc();
    chk("drain_ready", 64'(in_ready), 64'h1);

    // An illegal code, followed by a legal one.
    drive(1'b1, 5'h08, 64'h1234, 64'h0, 64'h0, 3'd2);
    cyc();
    drive(1'b1, 5'h0B, 64'hABCD, 64'h0, 64'h0, 3'd4);
    cyc();
    chk("ill_flag", 64'(out_illegal), 64'h1);
    chk("ill_y", out_y, 64'h0);
    drive(1'b0, 5'h0, 64'h0, 64'h0, 64'h0, 3'h0);
    cyc();
    chk("pass_y", out_y, 64'hABCD);
    chk("pass_flag", 64'(out_illegal), 64'h0);
    cyc();
    cyc();

    // Back-to-back stream of 16 ops with the writeback always ready.
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) drive(1'b1, 5'h09, 64'(i * 7 + 1), 64'(i), 64'h3, 3'(i));
      else        drive(1'b0, 5'h0, 64'h0, 64'h0, 64'h0, 3'h0);
      if (out_valid && out_ready) accepted++;
      cyc();
      chk("b2b_cnt_le1", 64'(count <= 1), 64'h1);
      if (i >= 1 && i <= 16) chk("b2b_valid", 64'(out_valid), 64'h1);
    end
    chk("b2b_accepted", 64'(accepted), 64'd16);

    // Flush with a full FIFO and a valid result; the push offered alongside is dropped.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'h03, 64'(k + 40), 64'h1, 64'h1, 3'(k));
      cyc();
    end
    flush = 1'b1;
    drive(1'b1, 5'h06, 64'h77, 64'h1, 64'h1, 3'd5);
    cyc();
    flush = 1'b0;
    drive(1'b0, 5'h0, 64'h0, 64'h0, 64'h0, 3'h0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_ready", 64'(in_ready), 64'h1);
    cyc();
    chk("flush_push_ignored", 64'(count), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 13));
      rfs = (r == 13) ? 5'h1F : 5'(r);
      drive($urandom_range(0, 3) != 0, rfs, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 3'($urandom_range(0, 7)));
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 29) == 0);
      cyc();
    end
    flush = 1'b0;

    // An asynchronous reset mid-stream empties everything at once.
    out_ready = 1'b0;
    drive(1'b1, 5'h01, 64'h5, 64'h6, 64'h7, 3'd1);
    cyc();
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'(out_valid), 64'h0);
    chk("async_ready", 64'(in_ready), 64'h1);
    do_reset();

`ifdef V_ALU_PERF_CNT_EN
    // Four accepted results and three stall cycles.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b1, 5'h0A, 64'(k), 64'h2, 64'h0, 3'(k));
      else       drive(1'b0, 5'h0, 64'h0, 64'h0, 64'h0, 3'h0);
      cyc();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    drive(1'b1, 5'h0B, 64'h44, 64'h0, 64'h0, 3'd6);
    cyc();
    drive(1'b0, 5'h0, 64'h0, 64'h0, 64'h0, 3'h0);
    for (int k = 0; k < 3; k++) cyc();
    chk("perf_ops_4", 64'(perf_ops), 64'd4);
    chk("perf_stall_3", 64'(perf_stall), 64'd3);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("perf_ops_flush", 64'(perf_ops), 64'd4);
    chk("perf_stall_flush", 64'(perf_stall), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("perf_ops_rst", 64'(perf_ops), 64'd0);
    chk("perf_stall_rst", 64'(perf_stall), 64'd0);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
